// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: FSM state encoding and the default
// bus widths / watchdog limit used as parameter defaults by apb_master.
package apb_pkg;

  localparam int unsigned APB_ADDR_W         = 32;
  localparam int unsigned APB_DATA_W         = 32;
  localparam int unsigned APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase watchdog for apb_master.
// Ports:
//   PCLK, PRESET : clock, asynchronous active-high reset
//   clear        : restart the count (asserted the cycle before ACCESS starts)
//   enable       : an ACCESS cycle in which the slave is still not ready
//   expired      : this enabled cycle is the LIMIT-th one; abort on this edge
module apb_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // expired is combinational so the abort lands on the same edge that would
  // have counted the LIMIT-th stalled cycle.
  assign expired = enable && (count == CW'(LIMIT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master bridging a cmd/rsp valid-ready interface to
// an APB (with PSTRB) bus. Every bus and cmd/rsp output is registered.
// Optional build macro: APB_MASTER_TIMEOUT_EN enables the ACCESS watchdog
// (apb_timeout_ctr); without it ACCESS waits forever and rsp_timeout is 0.
// Ports:
//   PCLK, PRESET                     : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_write/addr/wdata/strb        : command payload
//   rsp_valid/rsp_ready              : response handshake
//   rsp_rdata/rsp_err/rsp_timeout    : response payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB : APB request
//   PRDATA/PREADY/PSLVERR            : APB completion
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  if ((DATA_W % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("apb_master: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES nonzero");
  end

  apb_state_t state, state_nxt;

  logic                cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic                psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0]   paddr_nxt;
  logic [DATA_W-1:0]   pwdata_nxt, rsp_rdata_nxt;
  logic [DATA_W/8-1:0] pstrb_nxt;

`ifdef APB_MASTER_TIMEOUT_EN
  logic timeout_hit;
  logic rsp_timeout_nxt;

  apb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !PREADY),
    .expired (timeout_hit)
  );
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    psel_nxt      = PSEL;
    penable_nxt   = PENABLE;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    pstrb_nxt     = PSTRB;
    rsp_valid_nxt = rsp_valid;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_timeout_nxt = rsp_timeout;
`endif
    unique case (state)
      IDLE: begin
        // cmd_ready is registered, so it also gates the first cycle after reset.
        if (cmd_valid && cmd_ready) begin
          state_nxt   = SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_wdata;
          pstrb_nxt   = cmd_write ? cmd_strb : '0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the limit edge wins.
        if (PREADY) begin
          state_nxt     = RESP;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          pstrb_nxt     = '0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
          rsp_err_nxt   = PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_nxt = 1'b0;
        end else if (timeout_hit) begin
          state_nxt       = RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          pstrb_nxt       = '0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cmd_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cmd_ready <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      PSTRB     <= pstrb_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_timeout <= 1'b0;
    end else begin
      rsp_timeout <= rsp_timeout_nxt;
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a response scoreboard.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp_rsp;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat;
  int   n_acc;

  apb_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
  endtask

  // Called at a negedge with the DUT idle; returns at the first negedge after the accept edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [DW-1:0] e_rdata,
                       input logic e_err, input logic e_to);
    rsp_t e;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
    e.rdata = e_rdata;
    e.err   = e_err;
    e.to    = e_to;
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int start, input int limit, output int l);
    l = start;
    while (rsp_valid !== 1'b1 && l < limit) begin
      tick();
      l++;
    end
    check({tag, "_rsp_arrived"}, 64'(rsp_valid), 64'd1);
  endtask

  task automatic finish_rsp(input string tag);
    check({tag, "_sb_level"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      exp_rsp = sb.pop_front();
      check({tag, "_rdata"},   64'(rsp_rdata),   64'(exp_rsp.rdata));
      check({tag, "_err"},     64'(rsp_err),     64'(exp_rsp.err));
      check({tag, "_timeout"}, 64'(rsp_timeout), 64'(exp_rsp.to));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_psel",      64'(PSEL),      64'd0);
    check("rst_penable",   64'(PENABLE),   64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_paddr",     64'(PADDR),     64'd0);
    check("rst_pstrb",     64'(PSTRB),     64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    PRESET = 1'b0;
    #1;
    check("rel_cmd_ready_pre_edge", 64'(cmd_ready), 64'd0);
    tick();
    check("rel_cmd_ready_first_edge", 64'(cmd_ready), 64'd1);

    // Write, zero-wait slave
    PREADY = 1'b1;
    PRDATA = 32'h1111_2222;
    issue(1'b1, 32'h4, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 1'b0);
    check("wr_setup_psel",    64'(PSEL),      64'd1);
    check("wr_setup_penable", 64'(PENABLE),   64'd0);
    check("wr_setup_paddr",   64'(PADDR),     64'h4);
    check("wr_setup_pwdata",  64'(PWDATA),    64'hA5A5_0001);
    check("wr_setup_pstrb",   64'(PSTRB),     64'hF);
    check("wr_setup_pwrite",  64'(PWRITE),    64'd1);
    check("wr_setup_cmd_rdy", 64'(cmd_ready), 64'd0);
    tick();
    check("wr_access_psel",    64'(PSEL),    64'd1);
    check("wr_access_penable", 64'(PENABLE), 64'd1);
    wait_rsp("wr", 2, 20, lat);
    check("wr_latency",      64'(lat),     64'd3);
    check("wr_resp_psel",    64'(PSEL),    64'd0);
    check("wr_resp_penable", 64'(PENABLE), 64'd0);
    check("wr_resp_pstrb",   64'(PSTRB),   64'd0);
    check("wr_resp_paddr",   64'(PADDR),   64'h4);
    finish_rsp("wr");

    // Read with 3 wait states; PSLVERR noise during the waits must be ignored
    PREADY  = 1'b0;
    PSLVERR = 1'b1;
    PRDATA  = 32'h0BAD_0BAD;
    issue(1'b0, 32'h8, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("rd_setup_paddr",  64'(PADDR),  64'h8);
    check("rd_setup_pstrb",  64'(PSTRB),  64'd0);
    check("rd_setup_pwrite", 64'(PWRITE), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_wait_penable",   64'(PENABLE),   64'd1);
      check("rd_wait_paddr",     64'(PADDR),     64'h8);
      check("rd_wait_pstrb",     64'(PSTRB),     64'd0);
      check("rd_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'hDEAD_BEEF;
    wait_rsp("rd", 5, 20, lat);
    check("rd_latency", 64'(lat), 64'd6);
    finish_rsp("rd");

    // Read completing with PSLVERR
    PSLVERR = 1'b1;
    PRDATA  = 32'h1234_5678;
    issue(1'b0, 32'hC, 32'h0, 4'hF, 32'h1234_5678, 1'b1, 1'b0);
    wait_rsp("rderr", 1, 20, lat);
    check("rderr_latency", 64'(lat), 64'd3);
    finish_rsp("rderr");
    PSLVERR = 1'b0;

    // Response back-pressure with a command waiting
    PRDATA = 32'hCAFE_0042;
    issue(1'b0, 32'h18, 32'h0, 4'h0, 32'hCAFE_0042, 1'b0, 1'b0);
    wait_rsp("bp", 1, 20, lat);
    cmd_write = 1'b1;
    cmd_addr  = 32'h1C;
    cmd_wdata = 32'h5555_AAAA;
    cmd_strb  = 4'h5;
    cmd_valid = 1'b1;
    PRDATA    = 32'h0;
    PSLVERR   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_rdata",     64'(rsp_rdata), 64'hCAFE_0042);
      check("bp_hold_err",       64'(rsp_err),   64'd0);
      check("bp_hold_cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp_hold_psel",      64'(PSEL),      64'd0);
    end
    finish_rsp("bp");
    sb.push_back(rsp_t'{rdata: 32'h0, err: 1'b0, to: 1'b0});
    tick();
    cmd_valid = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = 32'h9999_9999;
    check("pend_psel",    64'(PSEL),    64'd1);
    check("pend_penable", 64'(PENABLE), 64'd0);
    check("pend_paddr",   64'(PADDR),   64'h1C);
    check("pend_pwdata",  64'(PWDATA),  64'h5555_AAAA);
    check("pend_pstrb",   64'(PSTRB),   64'h5);
    wait_rsp("pend", 1, 20, lat);
    check("pend_latency", 64'(lat), 64'd3);
    finish_rsp("pend");

    // Slave never ready
    PREADY = 1'b0;
    PRDATA = 32'h7777_7777;
`ifdef APB_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
    n_acc = 0;
    lat   = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (PENABLE === 1'b1) n_acc++;
      tick();
      lat++;
    end
    check("to_rsp_arrived",  64'(rsp_valid), 64'd1);
    check("to_latency",      64'(lat),       64'd6);
    check("to_access_count", 64'(n_acc),     64'd4);
    check("to_psel",         64'(PSEL),      64'd0);
    finish_rsp("to");
    issue(1'b0, 32'h14, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
    tick();
`else
    issue(1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
    repeat (100) tick();
    check("nto_psel",      64'(PSEL),        64'd1);
    check("nto_penable",   64'(PENABLE),     64'd1);
    check("nto_rsp_valid", 64'(rsp_valid),   64'd0);
    check("nto_timeout",   64'(rsp_timeout), 64'd0);
`endif

    // Reset pulse during ACCESS
    check("arst_pre_penable", 64'(PENABLE), 64'd1);
    #2;
    PRESET = 1'b1;
    #1;
    check("arst_psel",      64'(PSEL),      64'd0);
    check("arst_penable",   64'(PENABLE),   64'd0);
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_cmd_ready", 64'(cmd_ready), 64'd0);
    sb.delete();
    PREADY = 1'b1;
    tick();
    tick();
    check("arst_hold_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_hold_cmd_ready", 64'(cmd_ready), 64'd0);
    PRESET = 1'b0;
    tick();
    check("arst_rel_cmd_ready", 64'(cmd_ready), 64'd1);
    check("arst_rel_rsp_valid", 64'(rsp_valid), 64'd0);

    // Recovery write
    issue(1'b1, 32'h20, 32'h0BAD_F00D, 4'h3, 32'h0, 1'b0, 1'b0);
    check("rec_pstrb", 64'(PSTRB), 64'h3);
    wait_rsp("rec", 1, 20, lat);
    check("rec_latency", 64'(lat), 64'd3);
    finish_rsp("rec");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
